// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop, LSB first.
// Optional saturation on signed overflow when SERIAL_ADDER_SAT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit per cycle through the slice
// DONE  | one-cycle result-valid pulse; a new start is accepted here too
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             slice_s;
  logic             slice_co;

  assign slice_s  = a_q[0] ^ b_q[0] ^ carry_q;
  assign slice_co = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {slice_s, res_q[WIDTH-1:1]};
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB; a_q[0] is operand A's sign bit
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = {slice_s, res_q[WIDTH-1:1]};
          cout_d  = slice_co;
          ovf_d   = carry_q ^ slice_co;
`ifdef SERIAL_ADDER_SAT_EN
          if (carry_q ^ slice_co) begin
            sum_d = a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`else
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8): table of operations plus
// hand-written sequences for ignored start, back-to-back start and mid-op reset.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_total = 0;
  int n_pass  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Accepts an operation on the next edge, then counts cycles to done.
  task automatic run_op(input string name, input logic s, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic c, output int lat,
                        output int nbusy);
    sub = s; a = va; b = vb; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    check({name, " done_seen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int lat, nbusy, seen;
    vecs[0] = '{1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
`ifdef SERIAL_ADDER_SAT_EN
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h7F, 1'b0, 1'b1};
`else
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
`endif

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset sum", {24'd0, sum}, 32'd0);
    check("reset cout", {31'd0, cout}, 32'd0);
    check("reset ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
             lat, nbusy);
      check($sformatf("vec%0d latency", i), lat, 8);
      check($sformatf("vec%0d busy_cycles", i), nbusy, 8);
      check($sformatf("vec%0d sum", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
      check($sformatf("vec%0d cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
      check($sformatf("vec%0d ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      tick();
      check($sformatf("vec%0d done_pulse", i), {30'd0, done, busy}, 32'd0);
      check($sformatf("vec%0d sum_hold", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
    end

    // start during SHIFT ignored; then start held in DONE gets no bubble
    sub = 1'b0; a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'h11; b = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    check("ignored done_seen", {31'd0, done}, 32'd1);
    check("ignored sum", {24'd0, sum}, 32'h4B);
    start = 1'b1;
    tick();
    check("b2b busy_now", {31'd0, busy}, 32'd1);
    check("b2b done_low", {31'd0, done}, 32'd0);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin tick(); lat++; end
    check("b2b edges", lat, 9);
    check("b2b sum", {24'd0, sum}, 32'h33);
    check("b2b cout", {31'd0, cout}, 32'd0);
    tick();

    // reset in the 4th SHIFT cycle aborts
    sub = 1'b0; a = 8'h7F; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort sum", {24'd0, sum}, 32'd0);
    check("abort cout", {31'd0, cout}, 32'd0);
    check("abort ovf", {31'd0, overflow}, 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) seen = 1;
      tick();
    end
    check("abort no_done", seen, 0);

    run_op("fresh", 1'b0, 8'h3C, 8'h0F, 1'b0, lat, nbusy);
    check("fresh latency", lat, 8);
    check("fresh sum", {24'd0, sum}, 32'h4B);
    check("fresh ovf", {31'd0, overflow}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
